// File: rtl/uart_byte_ctrl.sv
// Byte-level UART controller: sequences TX handshake and buffers RX bytes in a FIFO for the core.
// Define UART_BYTE_CTRL_OVFCNT_EN to enable the saturating dropped-byte counter on ovf_cnt.
module uart_byte_ctrl #(
  parameter int RXDEPTH_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    go,
  input  logic                    send,
  input  logic [7:0]              wdata,
  output logic [7:0]              rdata,
  output logic                    done,
  output logic                    busy,
  output logic                    tx_start,
  output logic [7:0]              tx_byte,
  input  logic                    tx_busy,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  output logic [RXDEPTH_LOG2:0]   rx_count,
  output logic                    ovf,
  output logic [7:0]              ovf_cnt
);

  localparam int DEPTH = 1 << RXDEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_WAIT,
    S_TX_START,
    S_TX_ACK,
    S_TX_RUN,
    S_RX_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [7:0]              rdata_q;
  logic [7:0]              tx_byte_q;
  logic                    done_q;
  logic                    tx_start_q;
  logic                    busy_q;

  logic                    tx_busy_q;
  logic                    rx_valid_q;
  logic [7:0]              rx_byte_q;

  logic [7:0]              mem_q [DEPTH];
  logic [RXDEPTH_LOG2-1:0] wr_ptr_q;
  logic [RXDEPTH_LOG2-1:0] rd_ptr_q;
  logic [RXDEPTH_LOG2:0]   count_q;
  logic [RXDEPTH_LOG2:0]   count_d;
  logic                    ovf_q;

  logic                    full;
  logic                    pop;
  logic                    push;
  logic                    drop;

  assign full = (count_q == (RXDEPTH_LOG2 + 1)'(DEPTH));
  assign pop  = (state_q == S_RX_WAIT) && (count_q != '0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push = rx_valid_q && (!full || pop);
  assign drop = rx_valid_q && full && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Transmitter and receiver strobes are registered at the boundary before use.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
    end else begin
      tx_busy_q  <= tx_busy;
      rx_valid_q <= rx_valid;
      rx_byte_q  <= rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_byte_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      rdata_q    <= '0;
      tx_byte_q  <= '0;
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      tx_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            busy_q <= 1'b1;
            if (send) begin
              tx_byte_q <= wdata;
              state_q   <= S_TX_WAIT;
            end else begin
              state_q   <= S_RX_WAIT;
            end
          end
        end
        S_TX_WAIT: begin
          if (!tx_busy_q) begin
            tx_start_q <= 1'b1;
            state_q    <= S_TX_START;
          end
        end
        S_TX_START: state_q <= S_TX_ACK;
        S_TX_ACK: begin
          if (tx_busy_q) state_q <= S_TX_RUN;
        end
        S_TX_RUN: begin
          if (!tx_busy_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_RX_WAIT: begin
          if (pop) begin
            rdata_q <= mem_q[rd_ptr_q];
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_BYTE_CTRL_OVFCNT_EN
  logic [7:0] ovf_cnt_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_cnt_q <= '0;
    end else if (drop && (ovf_cnt_q != 8'hFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 8'h00;
`endif

  assign rdata    = rdata_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign rx_count = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_uart_byte_ctrl.sv
// Bench for uart_byte_ctrl: directed table, multi-cycle corner sequences and a randomized run
// against a transaction-level model (byte queue, occupancy arithmetic, transmitter model).
module tb_uart_byte_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       go;
  logic       send;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       done;
  logic       busy;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic [4:0] rx_count;
  logic       ovf;
  logic [7:0] ovf_cnt;

  uart_byte_ctrl #(.RXDEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn), .go(go), .send(send), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .tx_start(tx_start),
    .tx_byte(tx_byte), .tx_busy(tx_busy), .rx_valid(rx_valid),
    .rx_byte(rx_byte), .rx_count(rx_count), .ovf(ovf), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

`ifdef UART_BYTE_CTRL_OVFCNT_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif

  int total, bad, cyc;
  bit tx_model_en;
  int tx_hold, tx_len, tx_fall_cyc;
  bit [1:0] rxv_hist;
  int push_total, pop_total, push_issued;
  logic [7:0] exp_q[$];

  typedef struct {
    bit         s;
    logic [7:0] d;
    int         lat;
    int         st_lat;
    logic [7:0] exp;
    int         cnt;
  } vec_t;
  vec_t vecs[5];

  int lat, st_lat, nb, nd, st, dn, f0, req_cyc, last_done;
  logic [7:0] got, txb, req_dat;
  bit out_req, req_send, started;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: outputs are sampled 1ns after the edge; transmitter model reacts here.
  task automatic step();
    rxv_hist = {rxv_hist[0], rx_valid};
    @(posedge clk);
    #1;
    cyc++;
    push_total += int'(rxv_hist[1]);
    if (tx_model_en) begin
      if (tx_hold > 0) begin
        tx_busy = 1'b1;
        tx_hold--;
      end else begin
        if (tx_busy) tx_fall_cyc = cyc;
        tx_busy = 1'b0;
      end
      if (tx_start) tx_hold = tx_len;
    end
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_req(input bit s, input logic [7:0] d, output int l, output int sl,
                        output logic [7:0] g, output logic [7:0] tb);
    int t0;
    go = 1'b1; send = s; wdata = d;
    t0 = cyc; l = -1; sl = -1; g = '0; tb = '0;
    for (int k = 0; k < 100 && l < 0; k++) begin
      step();
      go = 1'b0;
      if (tx_start && sl < 0) begin sl = cyc - t0; tb = tx_byte; end
      if (done) begin l = cyc - t0; g = rdata; end
    end
  endtask

  task automatic wait_rx(input int wc, input logic [7:0] b, output int l,
                         output logic [7:0] g, output int nbad);
    int r;
    nbad = 0; l = -1; g = '0;
    go = 1'b1; send = 1'b0;
    step();
    go = 1'b0;
    for (int k = 0; k < wc; k++) begin
      if (!busy || done) nbad++;
      step();
    end
    rx_valid = 1'b1; rx_byte = b; r = cyc;
    for (int k = 0; k < 20 && l < 0; k++) begin
      step();
      rx_valid = 1'b0;
      if (done) begin l = cyc - r; g = rdata; end
      else if (!busy) nbad++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rstn = 1'b0; go = 1'b0; send = 1'b0; wdata = '0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_byte = '0;
    tx_model_en = 1'b0; tx_hold = 0; tx_len = 10; tx_fall_cyc = 0;
    rxv_hist = '0; push_total = 0; pop_total = 0; push_issued = 0;

    repeat (3) step();
    chk("rst_rdata", rdata, 0);
    chk("rst_tx_byte", tx_byte, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    rstn = 1'b1;
    step();

    // Directed transactions: sends use a 10-cycle transmitter, receives drain 0x11/0x22/0x33.
    vecs[0] = '{1'b1, 8'hA5, 15, 2,  8'hA5, 3};
    vecs[1] = '{1'b0, 8'h00, 2,  -1, 8'h11, 2};
    vecs[2] = '{1'b0, 8'h00, 2,  -1, 8'h22, 1};
    vecs[3] = '{1'b1, 8'h3C, 15, 2,  8'h3C, 1};
    vecs[4] = '{1'b0, 8'h00, 2,  -1, 8'h33, 0};
    tx_model_en = 1'b1; tx_len = 10;
    pulse_rx(8'h11); pulse_rx(8'h22); pulse_rx(8'h33);
    step(); step();
    chk("preload_count", rx_count, 3);
    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].s, vecs[i].d, lat, st_lat, got, txb);
      chk($sformatf("vec%0d_done_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_start_lat", i), st_lat, vecs[i].st_lat);
      chk($sformatf("vec%0d_data", i), vecs[i].s ? txb : got, vecs[i].exp);
      chk($sformatf("vec%0d_rx_count", i), rx_count, vecs[i].cnt);
      step();
      chk($sformatf("vec%0d_done_single", i), done, 0);
      chk($sformatf("vec%0d_busy_fall", i), busy, 0);
    end

    // Send while the transmitter is already busy.
    tx_model_en = 1'b0; tx_busy = 1'b1;
    step();
    go = 1'b1; send = 1'b1; wdata = 8'h69;
    step();
    go = 1'b0; nd = 0; nb = 0;
    repeat (8) begin
      if (tx_start) nd++;
      if (!busy) nb++;
      step();
    end
    chk("txwait_no_start", nd, 0);
    chk("txwait_busy", nb, 0);
    tx_model_en = 1'b1;
    step();
    f0 = tx_fall_cyc; st = -1; dn = -1; txb = '0;
    for (int k = 0; k < 60 && dn < 0; k++) begin
      if (tx_start && st < 0) begin st = cyc; txb = tx_byte; end
      if (done) dn = cyc;
      step();
    end
    chk("txwait_start_after_fall", st - f0, 2);
    chk("txwait_tx_byte", txb, 8'h69);
    chk("txwait_done_after_fall", dn - tx_fall_cyc, 2);

    // Receive on an empty FIFO, byte arrives 20 cycles later.
    wait_rx(20, 8'h5C, lat, got, nb);
    chk("rxwait_lat", lat, 3);
    chk("rxwait_rdata", got, 8'h5C);
    chk("rxwait_busy_held", nb, 0);
    step();

    // Overflow: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) pulse_rx(8'h80 + 8'(i));
    step();
    chk("ovf_count_full", rx_count, 16);
    chk("ovf_flag", ovf, 1);
    chk("ovf_cnt", ovf_cnt, OVF_EXP);
    go = 1'b1; send = 1'b0; rx_valid = 1'b1; rx_byte = 8'hEE;
    step();
    go = 1'b0; rx_valid = 1'b0;
    chk("simul_count_a", rx_count, 16);
    step();
    chk("simul_done", done, 1);
    chk("simul_rdata", rdata, 8'h80);
    chk("simul_count_b", rx_count, 16);
    chk("simul_ovf_cnt", ovf_cnt, OVF_EXP);
    step();
    chk("simul_done_single", done, 0);

    // Reset during TX_RUN with a full FIFO.
    go = 1'b1; send = 1'b1; wdata = 8'h5A;
    step();
    go = 1'b0;
    repeat (6) step();
    rstn = 1'b0;
    step();
    chk("txrst_busy", busy, 0);
    chk("txrst_done", done, 0);
    chk("txrst_rx_count", rx_count, 0);
    chk("txrst_tx_byte", tx_byte, 0);
    chk("txrst_ovf", ovf, 0);
    rstn = 1'b1; nd = 0;
    repeat (20) begin step(); if (done) nd++; end
    chk("txrst_no_done", nd, 0);
    chk("txrst_line_idle", tx_busy, 0);

    // Reset during RX_WAIT with five bytes queued.
    for (int i = 0; i < 5; i++) pulse_rx(8'h40 + 8'(i));
    step(); step();
    chk("rxrst_queued", rx_count, 5);
    go = 1'b1; send = 1'b0;
    step();
    go = 1'b0; rstn = 1'b0;
    step();
    chk("rxrst_busy", busy, 0);
    chk("rxrst_done", done, 0);
    chk("rxrst_rx_count", rx_count, 0);
    chk("rxrst_rdata", rdata, 0);
    rstn = 1'b1; nd = 0;
    repeat (10) begin step(); if (done) nd++; end
    chk("rxrst_no_done", nd, 0);
    wait_rx(8, 8'h77, lat, got, nb);
    chk("rxrst_fresh_lat", lat, 3);
    chk("rxrst_fresh_rdata", got, 8'h77);
    chk("rxrst_fresh_busy", nb, 0);
    step(); step();

    // Randomized traffic against the transaction model.
    push_total = 0; pop_total = 0; push_issued = 0; exp_q.delete();
    out_req = 1'b0; started = 1'b0; req_send = 1'b0; req_dat = '0; req_cyc = 0;
    last_done = cyc;
    chk("rand_start_count", rx_count, 0);
    for (int k = 0; k < 2000; k++) begin
      step();
      go = 1'b0; rx_valid = 1'b0;
      if (done) begin
        chk("rand_done_expected", out_req, 1);
        if (out_req && req_send) begin
          chk("rand_tx_started", started, 1);
          chk("rand_tx_done_lat", cyc - tx_fall_cyc, 2);
        end else if (out_req) begin
          pop_total++;
          if (exp_q.size() == 0) chk("rand_rx_queue", exp_q.size(), 1);
          else chk("rand_rdata", rdata, exp_q.pop_front());
        end
        out_req = 1'b0;
        last_done = cyc;
      end
      if (tx_start) begin
        chk("rand_tx_start_req", out_req && req_send && !started, 1);
        chk("rand_tx_start_lat", cyc - req_cyc, 2);
        chk("rand_tx_byte", tx_byte, req_dat);
        started = 1'b1;
      end
      chk("rand_rx_count", rx_count, push_total - pop_total);
      if (out_req && (cyc - req_cyc > 200)) begin
        chk("rand_req_timeout", out_req, 0);
        out_req = 1'b0;
      end
      if (!out_req && cyc > last_done && $urandom_range(0, 3) == 0) begin
        chk("rand_idle_busy", busy, 0);
        req_send = ($urandom_range(0, 1) == 1);
        req_dat  = 8'($urandom_range(0, 255));
        tx_len   = $urandom_range(1, 12);
        go = 1'b1; send = req_send; wdata = req_dat;
        req_cyc = cyc; out_req = 1'b1; started = 1'b0;
      end
      if ((push_issued - pop_total) < 15 && $urandom_range(0, 5) == 0) begin
        rx_valid = 1'b1;
        rx_byte  = 8'($urandom_range(0, 255));
        exp_q.push_back(rx_byte);
        push_issued++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_ctrl.md
# uart_byte_ctrl

Byte-level UART transfer controller between the multicycle core control FSM and the UART transmitter/receiver primitives. The core issues one send or receive request at a time and waits for a single-cycle completion pulse. The block buffers incoming bytes in an RX FIFO so that bytes arriving while the core is busy are not lost. It also sequences the transmitter handshake so the core never drives it directly.

## Interface
Parameters:
- RXDEPTH_LOG2, 4, log2 of RX FIFO depth (default 16 entries)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- go  in  1  request strobe from core; sampled only in IDLE
- send  in  1  request type, sampled with go: 1 = send byte, 0 = receive byte
- wdata  in  8  byte to send; sampled with go
- rdata  out  8  last received byte; valid from the done pulse of a receive, held until next receive completes
- done  out  1  one-cycle completion pulse
- busy  out  1  high in every state except IDLE
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_byte  out  8  byte to transmitter; stable from tx_start until next accepted send
- tx_busy  in  1  transmitter busy; rises within 1 cycle after tx_start, falls after the stop bit
- rx_valid  in  1  one-cycle pulse from receiver, byte on rx_byte
- rx_byte  in  8  received byte
- rx_count  out  RXDEPTH_LOG2+1  current FIFO occupancy
- ovf  out  1  sticky RX overflow flag
- ovf_cnt  out  8  dropped-byte count (see Configuration)

## Operation
States:
- IDLE: go&send → TX_WAIT (latch wdata); go&~send → RX_WAIT; go ignored in all other states.
- TX_WAIT: tx_busy=0 → TX_START; else stay.
- TX_START: tx_start=1 for this cycle only, tx_byte=latched byte → TX_ACK.
- TX_ACK: tx_busy=1 → TX_RUN; else stay.
- TX_RUN: tx_busy=0 → DONE.
- RX_WAIT: rx_count≠0 → pop FIFO head into rdata, → DONE; else stay.
- DONE: done=1 → IDLE.

RX FIFO:
- Circular buffer with RXDEPTH_LOG2-bit pointers that wrap modulo depth.
- Occupancy is RXDEPTH_LOG2+1 bits, range 0..2^RXDEPTH_LOG2.
- Push on rx_valid in any state when not full, or when full and a pop occurs in the same cycle.
- Simultaneous push and pop leaves rx_count unchanged.
- rx_valid when full with no pop: byte dropped, ovf set. ovf clears only on reset.
- No bypass: a byte arriving while RX_WAIT sees an empty FIFO is written first and popped on the following cycle.

Reset (rstn=0 at a clock edge):
- Outputs: state=IDLE, FIFO emptied, rdata=0, tx_byte=0, done=0, tx_start=0, busy=0, ovf=0, ovf_cnt=0.
- Reset mid-operation abandons the request and produces no done. A byte already handed to the transmitter continues on the line.

## Timing
- Send latency: with tx_busy=0, go at edge N gives tx_start high during cycle N+2.
  - done is asserted exactly 2 cycles after the first cycle in which tx_busy is sampled 0 in TX_RUN.
- Receive latency with FIFO non-empty: go in cycle N gives done and valid rdata in cycle N+2.
- Receive latency with FIFO empty: done follows 3 cycles after the rx_valid pulse (push, pop, DONE).
- done and tx_start are never high for more than one cycle.
- busy falls in the cycle after done, and a new go is accepted there.
- rx_count updates the cycle after a push or pop.

## Configuration
- UART_BYTE_CTRL_OVFCNT_EN
  - Defined: ovf_cnt increments on every dropped byte and saturates at 255.
  - Undefined: ovf_cnt is tied to 0 and the counter logic is absent. The ovf flag is unaffected.

## Test plan
- Send 0xA5 with tx_busy=0: tx_start pulses in cycle N+2 with tx_byte=0xA5. The bench model raises tx_busy for 10 cycles. done pulses once, 2 cycles after tx_busy falls.
- Send while tx_busy is already high: controller stays in TX_WAIT and tx_start is held 0 until tx_busy falls.
- Push 0x11, 0x22, 0x33 via rx_valid, then three receive requests: rdata returns 0x11, 0x22, 0x33 in order with one done each, and rx_count goes 3→0.
- Receive with empty FIFO, then rx_valid with 0x5C 20 cycles later: done 3 cycles after rx_valid with rdata=0x5C. busy stays high throughout the wait.
- Push 17 bytes with depth 16: byte 17 is dropped, ovf=1, and ovf_cnt=1 with the macro (0 without). With FIFO full, issue a pop and push in the same cycle: rx_count stays 16 and ovf_cnt does not increment.
- Assert rstn=0 during TX_RUN and during RX_WAIT with 5 bytes queued: no done, rx_count=0, busy=0 next cycle, and a fresh receive after reset waits for new data.
